// File: rtl/timer_scheduler.sv
// timer_scheduler: one countdown timer shared round-robin among N requesters.
// Define TIMER_SCHED_ABORT_EN to let the owner cancel its countdown by dropping req.
module timer_scheduler #(
   parameter int N = 4,
   parameter int W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       req_cycles,
   output logic [N-1:0]         grant,
   output logic [N-1:0]         done,
   output logic [$clog2(N)-1:0] active_id,
   output logic [W-1:0]         remaining,
   output logic                 busy
);
   localparam int AW = $clog2(N);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

   state_e        state_q, state_d;
   logic [W-1:0]  cnt_q, cnt_d;
   logic [AW-1:0] rr_q, rr_d;
   logic [AW-1:0] id_q, id_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [AW-1:0] win, idx, id_nxt;
   logic [W-1:0]  win_cycles;
   logic          found;
   logic          abort;

   // Scan requesters starting at the round-robin pointer.
   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = AW'((int'(rr_q) + i) % N);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      win_cycles = '0;
      for (int i = 0; i < N; i++) begin
         if (AW'(i) == win) win_cycles = req_cycles[i*W +: W];
      end
   end

   assign id_nxt = (id_q == AW'(N - 1)) ? '0 : id_q + 1'b1;

`ifdef TIMER_SCHED_ABORT_EN
   assign abort = (state_q == COUNT) && !req[id_q];
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rr_d    = rr_q;
      id_d    = id_q;
      grant_d = grant_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               grant_d      = '0;
               grant_d[win] = 1'b1;
               id_d         = win;
               cnt_d        = win_cycles;
               state_d      = (win_cycles == '0) ? DONE : COUNT;
            end
         end
         COUNT: begin
            if (abort) begin
               state_d = IDLE;
               grant_d = '0;
               id_d    = '0;
               cnt_d   = '0;
               rr_d    = id_nxt;
            end else if (cnt_q <= W'(1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            rr_d    = id_nxt;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rr_q    <= '0;
         id_q    <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         grant_q <= grant_d;
      end
   end

   assign grant     = grant_q;
   assign done      = (state_q == DONE) ? grant_q : '0;
   assign active_id = id_q;
   assign remaining = cnt_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed and randomized checks of timer_scheduler
// against a transaction-level round-robin model.
module tb_timer_scheduler;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int AW = $clog2(N);

   logic           clk = 1'b0;
   logic           reset_n;
   logic [N-1:0]   req;
   logic [N*W-1:0] req_cycles;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic [AW-1:0]  active_id;
   logic [W-1:0]   remaining;
   logic           busy;

   int errors = 0;
   int checks = 0;
   int rr_m = 0;
   int cyc_m [N];
   bit scramble = 1'b0;

   always #5 clk = ~clk;

   timer_scheduler #(.N(N), .W(W)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (req),
      .req_cycles (req_cycles),
      .grant      (grant),
      .done       (done),
      .active_id  (active_id),
      .remaining  (remaining),
      .busy       (busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_cyc(input int i, input int c);
      req_cycles[i*W +: W] = W'(c);
      cyc_m[i] = c;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"}, grant, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_id"}, active_id, 0);
      chk({tag, "_rem"}, remaining, 0);
   endtask

   function automatic int pick();
      for (int i = 0; i < N; i++)
         if (req[(rr_m + i) % N]) return (rr_m + i) % N;
      return -1;
   endfunction

   // Countdown from step k0 to completion, then the single idle cycle.
   task automatic cont_txn(input int w, input int c, input int k0);
      logic [N-1:0] oh;
      oh = '0;
      oh[w] = 1'b1;
      for (int k = k0; k <= c; k++) begin
         if (scramble) req_cycles[w*W +: W] = W'($urandom_range(0, 50));
         tick;
         chk("remaining", remaining, c - k);
         chk("grant_hold", grant, oh);
         chk("done", done, (k == c) ? oh : '0);
      end
      req[w] = 1'b0;
      tick;
      chk_idle("post_idle");
      rr_m = (w + 1) % N;
   endtask

   task automatic run_txn(input int w, input int c);
      logic [N-1:0] oh;
      oh = '0;
      oh[w] = 1'b1;
      tick;
      chk("grant", grant, oh);
      chk("active_id", active_id, w);
      chk("remaining0", remaining, c);
      chk("busy", busy, 1);
      chk("done0", done, (c == 0) ? oh : '0);
      cont_txn(w, c, 1);
   endtask

   task automatic do_reset;
      reset_n    = 1'b0;
      req        = '0;
      req_cycles = '0;
      tick;
      tick;
      reset_n = 1'b1;
      rr_m    = 0;
   endtask

   initial begin
      int w;
      int ord [5] = '{0, 1, 2, 3, 0};

      do_reset;
      chk_idle("reset");

      req = 4'b0001;
      set_cyc(0, 5);
      run_txn(0, 5);

      do_reset;
      req = 4'b0100;
      set_cyc(2, 0);
      run_txn(2, 0);

      do_reset;
      req = 4'b1111;
      for (int i = 0; i < N; i++) set_cyc(i, 2);
      for (int n = 0; n < 5; n++) begin
         run_txn(ord[n], 2);
         if (n == 0) req[0] = 1'b1;
      end

      do_reset;
      req = 4'b0010;
      set_cyc(1, 100);
      tick;
      chk("rst_grant", grant, 4'b0010);
      repeat (60) tick;
      chk("rst_rem40", remaining, 40);
      reset_n = 1'b0;
      req     = 4'b1000;
      set_cyc(3, 2);
      tick;
      chk_idle("midreset");
      reset_n = 1'b1;
      rr_m    = 0;
      run_txn(3, 2);

      do_reset;
      req = 4'b0011;
      set_cyc(0, 10);
      set_cyc(1, 3);
      tick;
      chk("ab_grant", grant, 4'b0001);
      chk("ab_rem10", remaining, 10);
      repeat (4) tick;
      chk("ab_rem6", remaining, 6);
      req[0] = 1'b0;
`ifdef TIMER_SCHED_ABORT_EN
      tick;
      chk_idle("abort");
      rr_m = 1;
`else
      cont_txn(0, 10, 5);
`endif
      run_txn(1, 3);

      do_reset;
      scramble = 1'b1;
      repeat (80) begin
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               set_cyc(i, $urandom_range(0, 6));
            end
         end
         w = pick();
         if (w < 0) begin
            tick;
            chk_idle("rand_idle");
         end else begin
            run_txn(w, cyc_m[w]);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares a single 16-bit countdown timer between N requesters. Each requester asks for a delay of a given number of cycles; the scheduler grants the timer round-robin, loads and runs the countdown, and pulses a per-requester `done` when the delay expires. It sits between client FSMs and the timing resource, so clients never touch the counter directly.

## Interface
Parameters:
- `N`, 4, number of requesters (2..8)
- `W`, 16, counter width

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  synchronous reset, active-low
- `req`  in  N  request; bit i held high by requester i until its `done[i]`
- `req_cycles`  in  N*W  delay per requester, slice i = bits [i*W +: W]; stable while `req[i]` high
- `grant`  out  N  one-hot owner of the timer; all zero when idle
- `done`  out  N  one-cycle pulse to the owner when its delay expires
- `active_id`  out  $clog2(N)  index of current owner; 0 when idle
- `remaining`  out  W  current counter value
- `busy`  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, COUNT, DONE.
- IDLE: if any `req` bit high, pick winner by round-robin starting at pointer `rr`. Next edge: `grant` ← onehot(winner), `active_id` ← winner, counter ← `req_cycles[winner]`, state ← COUNT, or DONE directly if that value is 0.
- COUNT: counter decrements by 1 each edge. On the edge where counter == 1: counter ← 0, state ← DONE.
- DONE: `done` = `grant` (combinational decode of state DONE and grant). Next edge: state ← IDLE, `grant` ← 0, `active_id` ← 0, `rr` ← (winner + 1) mod N.
- No arbitration in COUNT or DONE; requests wait. Counter never wraps: decrement only when nonzero.
- Requester must drop `req[i]` in the cycle `done[i]` is high; if still high in the following IDLE cycle it is treated as a new request, ranked last behind others because `rr` has advanced.
- Changing `req_cycles[i]` while granted has no effect; the value is sampled only at grant.

## Timing
- Reset (`reset_n` low at an edge): state IDLE, counter 0, `rr` 0, `grant` 0, `done` 0, `active_id` 0, `remaining` 0, `busy` 0. Takes priority over everything, including mid-COUNT; no `done` pulse issued for the aborted request.
- Request with value C ≥ 1 sampled at edge E0: `grant` high for C+1 cycles; `remaining` = C−k after edge Ek; `done` high during the cycle after edge EC; `grant` low after EC+1.
- C = 0: `grant` and `done` both high in the single cycle after E0.
- Back-to-back: minimum one IDLE cycle between consecutive grants; `busy` low for exactly that cycle.
- Request-to-grant latency when idle: 1 cycle.

## Configuration
- `TIMER_SCHED_ABORT_EN` defined: in COUNT, if `req[active_id]` falls low, the next edge goes to IDLE, `grant` ← 0, counter ← 0, `rr` advances past the owner, no `done` pulse. DONE is unaffected.
- Not defined: `req` is sampled only in IDLE; a started countdown always completes and always pulses `done`.

## Test plan
- Single request: `req`=0001, `req_cycles[0]`=5 -> `grant`=0001 for 6 cycles, `remaining` 5,4,3,2,1,0, `done[0]` pulse in 6th granted cycle, `busy` low one cycle later.
- Zero delay: `req[2]`, cycles 0 -> `grant`=0100 and `done`=0100 in same single cycle.
- Round-robin: all four `req` held, cycles 2 each, requesters dropping `req` on `done` -> grant order 0,1,2,3; a re-asserted `req[0]` after its done is served after 1,2,3.
- Reset mid-count: `req[1]`, cycles 100, `reset_n` low at `remaining`=40 -> next cycle all outputs 0, no `done`; after release, `req[3]` wins first (`rr`=0 ranks 0..3, only 3 requesting).
- Abort (macro on): `req[0]` cycles 10, drop `req[0]` at `remaining`=6 -> `grant` 0 next cycle, no `done`; pending `req[1]` granted one cycle later. Macro off: same stimulus -> countdown completes, `done[0]` pulses.
